icache_boot_loader: RTL and testbench

Sequences the instruction-cache fill port of PA_Core: it streams a block of 60-bit instructions from a host or boot source into the icache and keeps the core halted until the load is complete. It sits between the boot/host interface and the core's halt_i, icacheWriteEnable_i, writeAddress_i and instruction_i inputs. It also supports a reload while the core is running: it re-halts the core, waits a fixed pipeline-drain interval, then refills.

---
 rtl/pa_boot_pkg.sv | 25 ++
 rtl/boot_drain_counter.sv | 35 +++
 rtl/icache_boot_loader.sv | 153 +++++++++++++++
 tb/tb_icache_boot_loader.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pa_boot_pkg.sv
// Shared boot-loader definitions: FSM state encoding and the instruction-cache
// geometry that PA_Core is built with.
// No ports; imported by the loader and its drain counter.
package pa_boot_pkg;

  // Icache geometry, shared with PA_Core.
  localparam int PA_ADDR_WIDTH   = 16;
  localparam int PA_INST_WIDTH   = 60;

  // Wide enough for drain intervals of 1..15 cycles.
  localparam int DRAIN_CNT_WIDTH = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DRAIN   = 3'd1,
    LOAD    = 3'd2,
    RELEASE = 3'd3,
    RUN     = 3'd4
  } boot_state_t;

  function automatic logic is_busy_state(input boot_state_t s);
    return (s == DRAIN) || (s == LOAD) || (s == RELEASE);
  endfunction

endpackage

// File: rtl/boot_drain_counter.sv
// Purpose: loadable down-counter timing the pipeline drain after re-halting the core.
// Latency: term is registered state; it is high while the count reads 1.
// Backpressure: none; load wins over dec, and the count saturates at 0.
// Ports: clock/reset (sync, active-high); load/load_value preset the count;
//        dec decrements by one; term flags a count of exactly 1.
module boot_drain_counter
  import pa_boot_pkg::*;
#(
  parameter int WIDTH = DRAIN_CNT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic             term
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  // Terminal at 1 so the caller leaves its wait state on the same edge the
  // counter would reach 0.
  assign term = (count == WIDTH'(1));

endmodule

// File: rtl/icache_boot_loader.sv
// Purpose: streams a block of instructions into the PA_Core icache fill port, holding the core halted meanwhile.
// Latency: a beat accepted at edge N is written during cycle N..N+1; from IDLE, halt_o falls L+2 edges after start.
// Backpressure: valid/ready on the instruction source; instReady_o is registered and only high in LOAD.
// Ports: clock_i/reset_i (sync, active-high); start_i/baseAddr_i/length_i load request;
//        instValid_i/instData_i/instReady_o source handshake; halt_o, icacheWriteEnable_o,
//        writeAddress_o, instruction_o drive the core; busy_o, done_o, error_o status.
module icache_boot_loader
  import pa_boot_pkg::*;
#(
  parameter int ADDR_WIDTH   = PA_ADDR_WIDTH,
  parameter int INST_WIDTH   = PA_INST_WIDTH,
  parameter int DRAIN_CYCLES = 4              // legal range 1..15
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] baseAddr_i,
  input  logic [ADDR_WIDTH-1:0] length_i,
  input  logic                  instValid_i,
  input  logic [INST_WIDTH-1:0] instData_i,
  output logic                  instReady_o,
  output logic                  halt_o,
  output logic                  icacheWriteEnable_o,
  output logic [ADDR_WIDTH-1:0] writeAddress_o,
  output logic [INST_WIDTH-1:0] instruction_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o
);

  // One past the last icache address, as a 17-bit value.
  localparam logic [ADDR_WIDTH:0] ADDR_SPACE = {1'b1, {ADDR_WIDTH{1'b0}}};

  boot_state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] rem_q, rem_d;

  logic                  ready_d, halt_d, we_d, busy_d, done_d, error_d;
  logic [ADDR_WIDTH-1:0] waddr_d;
  logic [INST_WIDTH-1:0] inst_d;

  logic                  drain_load, drain_term;
  logic [ADDR_WIDTH:0]   req_end;
  logic                  req_ok;
  logic                  accept;

  // Rejecting any block that would run past the top of the icache means the
  // address counter can never wrap mid-load.
  assign req_end = {1'b0, baseAddr_i} + {1'b0, length_i};
  assign req_ok  = (length_i != '0) && (req_end <= ADDR_SPACE);

  // instReady_o is only ever high in LOAD, so no state qualifier is needed.
  assign accept  = instValid_i && instReady_o;

  boot_drain_counter #(
    .WIDTH(DRAIN_CNT_WIDTH)
  ) u_drain (
    .clock      (clock_i),
    .reset      (reset_i),
    .load       (drain_load),
    .load_value (DRAIN_CNT_WIDTH'(DRAIN_CYCLES)),
    .dec        (state_q == DRAIN),
    .term       (drain_term)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    we_d       = 1'b0;
    waddr_d    = writeAddress_o;
    inst_d     = instruction_o;
    done_d     = 1'b0;
    error_d    = 1'b0;
    drain_load = 1'b0;

    unique case (state_q)
      IDLE, RUN: begin
        if (start_i) begin
          if (req_ok) begin
            addr_d = baseAddr_i;
            rem_d  = length_i;
            if (state_q == RUN) begin
              // The running core needs time to flush in-flight fetches
              // before its icache is overwritten.
              state_d    = DRAIN;
              drain_load = 1'b1;
            end else begin
              state_d = LOAD;
            end
          end else begin
            error_d = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (drain_term) state_d = LOAD;
      end
      LOAD: begin
        if (accept) begin
          we_d    = 1'b1;
          waddr_d = addr_q;
          inst_d  = instData_i;
          addr_d  = addr_q + ADDR_WIDTH'(1);
          rem_d   = rem_q - ADDR_WIDTH'(1);
          if (rem_q == ADDR_WIDTH'(1)) state_d = RELEASE;
        end
      end
      RELEASE: begin
        // The final write strobe is visible during this cycle.
        done_d  = 1'b1;
        state_d = RUN;
      end
      default: state_d = IDLE;
    endcase

    // Ready rises one cycle after LOAD is entered and falls on the edge that
    // takes the final beat.
    ready_d = (state_q == LOAD) && (state_d == LOAD);
    halt_d  = (state_d != RUN);
    busy_d  = is_busy_state(state_d);
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q             <= IDLE;
      addr_q              <= '0;
      rem_q               <= '0;
      instReady_o         <= 1'b0;
      halt_o              <= 1'b1;
      icacheWriteEnable_o <= 1'b0;
      writeAddress_o      <= '0;
      instruction_o       <= '0;
      busy_o              <= 1'b0;
      done_o              <= 1'b0;
      error_o             <= 1'b0;
    end else begin
      state_q             <= state_d;
      addr_q              <= addr_d;
      rem_q               <= rem_d;
      instReady_o         <= ready_d;
      halt_o              <= halt_d;
      icacheWriteEnable_o <= we_d;
      writeAddress_o      <= waddr_d;
      instruction_o       <= inst_d;
      busy_o              <= busy_d;
      done_o              <= done_d;
      error_o             <= error_d;
    end
  end

endmodule

// File: tb/tb_icache_boot_loader.sv
// Directed bench for icache_boot_loader: every accepted beat pushes its expected
// {address, instruction} into a scoreboard that the write monitor pops; latency,
// pulse and halt behaviour are compared against constants derived from the protocol.
module tb_icache_boot_loader;

  logic        clock_i;
  logic        reset_i;
  logic        start_i;
  logic [15:0] baseAddr_i;
  logic [15:0] length_i;
  logic        instValid_i;
  logic [59:0] instData_i;
  logic        instReady_o;
  logic        halt_o;
  logic        icacheWriteEnable_o;
  logic [15:0] writeAddress_o;
  logic [59:0] instruction_o;
  logic        busy_o;
  logic        done_o;
  logic        error_o;

  icache_boot_loader #(
    .ADDR_WIDTH  (16),
    .INST_WIDTH  (60),
    .DRAIN_CYCLES(4)
  ) dut (
    .clock_i             (clock_i),
    .reset_i             (reset_i),
    .start_i             (start_i),
    .baseAddr_i          (baseAddr_i),
    .length_i            (length_i),
    .instValid_i         (instValid_i),
    .instData_i          (instData_i),
    .instReady_o         (instReady_o),
    .halt_o              (halt_o),
    .icacheWriteEnable_o (icacheWriteEnable_o),
    .writeAddress_o      (writeAddress_o),
    .instruction_o       (instruction_o),
    .busy_o              (busy_o),
    .done_o              (done_o),
    .error_o             (error_o)
  );

  int checks   = 0;
  int failures = 0;
  int edges    = 0;
  int wr_count = 0;
  int err_count = 0;

  logic [75:0] sb[$];

  int   s_edge, done_edge, first_ready, halt_fall;
  logic halt_at_s, busy_at_s, halt_at_done, busy_at_done, done_next;

  initial clock_i = 1'b0;
  always #5 clock_i = ~clock_i;

  always @(posedge clock_i) edges <= edges + 1;

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [75:0] obs, input logic [75:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Write monitor: every strobe must match the oldest expected beat.
  always @(negedge clock_i) begin
    if (icacheWriteEnable_o) begin
      logic [75:0] exp_w;
      wr_count++;
      exp_w = (sb.size() != 0) ? sb.pop_front() : 'x;
      chk("sb_write", {writeAddress_o, instruction_o}, exp_w);
    end
    if (error_o) err_count++;
  end

  task automatic check_reset_outputs(input string pfx);
    chk({pfx, "_halt"},  76'(halt_o),              76'(1));
    chk({pfx, "_ready"}, 76'(instReady_o),         76'(0));
    chk({pfx, "_we"},    76'(icacheWriteEnable_o), 76'(0));
    chk({pfx, "_busy"},  76'(busy_o),              76'(0));
    chk({pfx, "_done"},  76'(done_o),              76'(0));
    chk({pfx, "_err"},   76'(error_o),             76'(0));
    chk({pfx, "_waddr"}, 76'(writeAddress_o),      76'(0));
    chk({pfx, "_inst"},  76'(instruction_o),       76'(0));
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    @(negedge clock_i);
    @(negedge clock_i);
    reset_i = 1'b0;
    @(negedge clock_i);
  endtask

  // Issues a start, then feeds len beats. gap_at/gap_len hold the source idle
  // before beat gap_at; poke_at pulses a (valid) start mid-load; abort_at
  // asserts reset once abort_at beats have been written.
  task automatic do_load(input logic [15:0] base, input int len, input int gap_at,
                         input int gap_len, input int poke_at, input int abort_at);
    int          i, gap, budget, cur_idx;
    logic [59:0] cur;
    bit          poked;
    i = 0; gap = 0; budget = 0; cur_idx = -1; cur = '0; poked = 1'b0;
    done_edge = -1; first_ready = -1; halt_fall = -1; done_next = 1'bx;
    halt_at_done = 1'bx; busy_at_done = 1'bx;
    baseAddr_i  = base;
    length_i    = 16'(len);
    start_i     = 1'b1;
    instValid_i = 1'b0;
    @(negedge clock_i);
    s_edge    = edges;
    halt_at_s = halt_o;
    busy_at_s = busy_o;
    start_i   = 1'b0;
    while (budget < 80) begin
      if (done_edge >= 0) begin
        done_next = done_o;
        break;
      end
      if (done_o) begin
        done_edge    = edges;
        halt_at_done = halt_o;
        busy_at_done = busy_o;
      end
      if (instReady_o && first_ready < 0) first_ready = edges;
      if (!halt_o && halt_fall < 0) halt_fall = edges;
      if (abort_at >= 0 && i == abort_at) begin
        reset_i     = 1'b1;
        instValid_i = 1'b1;
        instData_i  = 60'({$urandom(), $urandom()});
        @(negedge clock_i);
        break;
      end
      start_i = 1'b0;
      if (poke_at >= 0 && i == poke_at && !poked) begin
        start_i    = 1'b1;
        baseAddr_i = 16'h0300;
        length_i   = 16'd1;
        poked      = 1'b1;
      end
      if (i < len && i == gap_at && gap < gap_len) begin
        instValid_i = 1'b0;
        gap++;
      end else if (i < len) begin
        if (cur_idx != i) begin
          cur     = 60'({$urandom(), $urandom()});
          cur_idx = i;
        end
        instValid_i = 1'b1;
        instData_i  = cur;
        // Ready is registered, so seeing it here means the beat is taken at
        // the coming edge.
        if (instReady_o) begin
          sb.push_back({base + 16'(i), cur});
          i++;
        end
      end else begin
        instValid_i = 1'b0;
      end
      @(negedge clock_i);
      budget++;
    end
    start_i     = 1'b0;
    instValid_i = 1'b0;
    if (abort_at < 0) chk_int("load_done_seen", int'(done_edge >= 0), 1);
  endtask

  task automatic bad_req(input logic [15:0] base, input logic [15:0] len,
                         input logic exp_halt, input string tag);
    int w0, e0;
    w0 = wr_count;
    e0 = err_count;
    baseAddr_i = base;
    length_i   = len;
    start_i    = 1'b1;
    @(negedge clock_i);
    start_i = 1'b0;
    chk({tag, "_err_pulse"}, 76'(error_o), 76'(1));
    chk({tag, "_halt"},      76'(halt_o),  76'(exp_halt));
    chk({tag, "_busy"},      76'(busy_o),  76'(0));
    @(negedge clock_i);
    chk({tag, "_err_end"},   76'(error_o), 76'(0));
    chk({tag, "_halt2"},     76'(halt_o),  76'(exp_halt));
    chk({tag, "_ready"},     76'(instReady_o), 76'(0));
    chk_int({tag, "_no_write"}, wr_count - w0, 0);
    chk_int({tag, "_err_count"}, err_count - e0, 1);
  endtask

  initial begin
    int w0, e0;
    reset_i     = 1'b1;
    start_i     = 1'b0;
    baseAddr_i  = '0;
    length_i    = '0;
    instValid_i = 1'b0;
    instData_i  = '0;
    repeat (3) @(negedge clock_i);
    check_reset_outputs("reset");
    reset_i = 1'b0;
    @(negedge clock_i);
    chk("idle_halt", 76'(halt_o), 76'(1));

    // Back-to-back load of three beats from IDLE.
    w0 = wr_count; e0 = err_count;
    do_load(16'h0010, 3, -1, 0, -1, -1);
    chk("s1_halt_at_start", 76'(halt_at_s), 76'(1));
    chk("s1_busy_at_start", 76'(busy_at_s), 76'(1));
    chk_int("s1_first_ready", first_ready - s_edge, 1);
    chk_int("s1_done_latency", done_edge - s_edge, 5);
    chk_int("s1_halt_fall", halt_fall - s_edge, 5);
    chk("s1_halt_at_done", 76'(halt_at_done), 76'(0));
    chk("s1_busy_at_done", 76'(busy_at_done), 76'(0));
    chk("s1_done_width", 76'(done_next), 76'(0));
    chk_int("s1_writes", wr_count - w0, 3);
    chk_int("s1_sb_empty", sb.size(), 0);
    chk_int("s1_no_error", err_count - e0, 0);

    // Source stalls for two cycles between B and C.
    do_reset();
    w0 = wr_count;
    do_load(16'h0010, 3, 2, 2, -1, -1);
    chk_int("s2_done_latency", done_edge - s_edge, 7);
    chk_int("s2_halt_fall", halt_fall - s_edge, 7);
    chk_int("s2_writes", wr_count - w0, 3);
    chk_int("s2_sb_empty", sb.size(), 0);

    // Rejected requests from IDLE, then a block ending exactly at the top.
    do_reset();
    bad_req(16'h0000, 16'd0, 1'b1, "bad_len0_idle");
    bad_req(16'hFFFE, 16'd3, 1'b1, "bad_wrap_idle");
    w0 = wr_count;
    do_load(16'hFFFE, 2, -1, 0, -1, -1);
    chk_int("edge_done_latency", done_edge - s_edge, 4);
    chk_int("edge_writes", wr_count - w0, 2);
    chk_int("edge_sb_empty", sb.size(), 0);
    bad_req(16'h0000, 16'd0, 1'b0, "bad_len0_run");
    bad_req(16'h8000, 16'h8001, 1'b0, "bad_wrap_run");

    // Reload while the core runs: halt, drain four cycles, write one beat.
    w0 = wr_count;
    do_load(16'h0100, 1, -1, 0, -1, -1);
    chk("s4_halt_at_start", 76'(halt_at_s), 76'(1));
    chk("s4_busy_at_start", 76'(busy_at_s), 76'(1));
    chk_int("s4_first_ready", first_ready - s_edge, 5);
    chk_int("s4_done_latency", done_edge - s_edge, 7);
    chk("s4_halt_at_done", 76'(halt_at_done), 76'(0));
    chk_int("s4_writes", wr_count - w0, 1);
    chk_int("s4_sb_empty", sb.size(), 0);

    // Reset after two of five beats.
    do_reset();
    w0 = wr_count;
    do_load(16'h0040, 5, -1, 0, -1, 2);
    check_reset_outputs("midreset");
    chk_int("midreset_two_writes", wr_count - w0, 2);
    chk_int("midreset_sb_empty", sb.size(), 0);
    reset_i = 1'b0;
    w0 = wr_count;
    instValid_i = 1'b1;
    repeat (6) @(negedge clock_i);
    instValid_i = 1'b0;
    chk_int("midreset_no_more_writes", wr_count - w0, 0);
    chk("midreset_halt_held", 76'(halt_o), 76'(1));
    chk("midreset_ready_low", 76'(instReady_o), 76'(0));

    // A start during LOAD must be ignored without an error pulse.
    w0 = wr_count; e0 = err_count;
    do_load(16'h0200, 4, -1, 0, 2, -1);
    chk_int("s6_done_latency", done_edge - s_edge, 6);
    chk_int("s6_writes", wr_count - w0, 4);
    chk_int("s6_sb_empty", sb.size(), 0);
    chk_int("s6_no_error", err_count - e0, 0);
    chk("s6_halt_released", 76'(halt_o), 76'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
